// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Purpose:
//   Decodes a raw RV32I/RV64I instruction word. Selects ALU operands A and B,
//   and the store data. Resolves rs1/rs2 hazards against NFWD forwarding
//   sources. Forwarding source 0 is the youngest and wins ties. The result is
//   held in an ID/EX pipeline register with a valid/ready handshake. The stage
//   also supports flush and keeps a saturating count of stalled cycles.
//
// Ports:
//   clk_i             clock, rising edge
//   reset_i           synchronous, active-high reset
//   in_valid_i        upstream presents an instruction
//   in_ready_o        stage can accept this cycle (combinational)
//   instr_i           raw 32-bit instruction word
//   pc_i              instruction address
//   rs1_data_i        register-file read of rs1
//   rs2_data_i        register-file read of rs2
//   fwd_valid_i       per-source forwarding valid
//   fwd_rd_i          per-source destination register, slice i = [5i+4:5i]
//   fwd_data_i        per-source result, slice i = [XLEN*i +: XLEN]
//   flush_i           squash the stage contents
//   out_valid_o       registered operands valid
//   out_ready_i       downstream accepts
//   out_a_o           operand A
//   out_b_o           operand B
//   out_store_data_o  forwarded rs2 for stores, else 0
//   out_funct_o       {alt bit, funct3} ALU function
//   out_alu_en_o      instruction uses the ALU
//   out_rd_o          destination register (0 when nothing is written)
//   stall_cnt_o       saturating count of stalled cycles
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int NFWD  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      rs1_data_i,
  input  logic [XLEN-1:0]      rs2_data_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [5*NFWD-1:0]    fwd_rd_i,
  input  logic [XLEN*NFWD-1:0] fwd_data_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      out_a_o,
  output logic [XLEN-1:0]      out_b_o,
  output logic [XLEN-1:0]      out_store_data_o,
  output logic [3:0]           out_funct_o,
  output logic                 out_alu_en_o,
  output logic [4:0]           out_rd_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Sign-extend a 32-bit value to XLEN. The signed size cast sign-extends
  // when XLEN is 64 and passes the value through unchanged when XLEN is 32.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Pick the operand value for one source register. The loop runs from the
  // oldest source down to the youngest, so the lowest matching index wins.
  // x0 always reads as zero, whatever the register file or forwarding say.
  function automatic logic [XLEN-1:0] fwd_select(
    input logic [4:0]           rs,
    input logic [XLEN-1:0]      rf_val,
    input logic [NFWD-1:0]      fv,
    input logic [5*NFWD-1:0]    frd,
    input logic [XLEN*NFWD-1:0] fdata
  );
    logic [XLEN-1:0] r;
    r = rf_val;
    for (int i = NFWD - 1; i >= 0; i--) begin
      r = (fv[i] && (frd[5*i +: 5] == rs)) ? fdata[XLEN*i +: XLEN] : r;
    end
    return (rs == 5'd0) ? {XLEN{1'b0}} : r;
  endfunction

  // Instruction fields
  logic [6:0] opcode_s;
  logic [4:0] rd_s;
  logic [2:0] funct3_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;

  assign opcode_s = instr_i[6:0];
  assign rd_s     = instr_i[11:7];
  assign funct3_s = instr_i[14:12];
  assign rs1_s    = instr_i[19:15];
  assign rs2_s    = instr_i[24:20];

  // Forwarded source operands and immediates
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] shamt_s;

  assign rs1_val_s = fwd_select(rs1_s, rs1_data_i, fwd_valid_i, fwd_rd_i, fwd_data_i);
  assign rs2_val_s = fwd_select(rs2_s, rs2_data_i, fwd_valid_i, fwd_rd_i, fwd_data_i);
  assign imm_i_s   = sext32({{20{instr_i[31]}}, instr_i[31:20]});
  assign imm_s_s   = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
  assign imm_u_s   = sext32({instr_i[31:12], 12'b0});

  // Shift amount is 5 bits on RV32 and 6 bits on RV64, and is zero-extended
  always_comb begin
    shamt_s = {XLEN{1'b0}};
    if (XLEN == 64) begin
      shamt_s = XLEN'(instr_i[25:20]);
    end else begin
      shamt_s = XLEN'(instr_i[24:20]);
    end
  end

  // Decoded next-state values for the pipeline register
  logic [XLEN-1:0] a_d;
  logic [XLEN-1:0] b_d;
  logic [XLEN-1:0] store_d;
  logic [3:0]      funct_d;
  logic            alu_en_d;
  logic [4:0]      rd_d;

  // Opcode decode: operand selection, ALU function and destination register
  always_comb begin
    a_d      = {XLEN{1'b0}};
    b_d      = {XLEN{1'b0}};
    store_d  = {XLEN{1'b0}};
    funct_d  = 4'b0000;
    alu_en_d = 1'b0;
    rd_d     = 5'd0;
    case (opcode_s)
      OPC_OP_IMM: begin
        a_d = rs1_val_s;
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          b_d = shamt_s;
        end else begin
          b_d = imm_i_s;
        end
        // instr[30] carries the alt bit only for SRAI. For the other OP-IMM
        // encodings it is ordinary immediate data.
        funct_d  = {(funct3_s == 3'b101) ? instr_i[30] : 1'b0, funct3_s};
        alu_en_d = 1'b1;
        rd_d     = rd_s;
      end
      OPC_OP: begin
        a_d      = rs1_val_s;
        b_d      = rs2_val_s;
        funct_d  = {instr_i[30], funct3_s};
        alu_en_d = 1'b1;
        rd_d     = rd_s;
      end
      OPC_LOAD: begin
        a_d      = rs1_val_s;
        b_d      = imm_i_s;
        alu_en_d = 1'b1;
        rd_d     = rd_s;
      end
      OPC_STORE: begin
        a_d      = rs1_val_s;
        b_d      = imm_s_s;
        store_d  = rs2_val_s;
        alu_en_d = 1'b1;
      end
      OPC_LUI: begin
        b_d      = imm_u_s;
        alu_en_d = 1'b1;
        rd_d     = rd_s;
      end
      OPC_AUIPC: begin
        a_d      = pc_i;
        b_d      = imm_u_s;
        alu_en_d = 1'b1;
        rd_d     = rd_s;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU computes the link address PC + 4
        a_d      = pc_i;
        b_d      = XLEN'(4'd4);
        alu_en_d = 1'b1;
        rd_d     = rd_s;
      end
      default: begin
        a_d      = {XLEN{1'b0}};
        b_d      = {XLEN{1'b0}};
        store_d  = {XLEN{1'b0}};
        funct_d  = 4'b0000;
        alu_en_d = 1'b0;
        rd_d     = 5'd0;
      end
    endcase
  end

  // Pipeline register state
  logic             valid_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  store_q;
  logic [3:0]       funct_q;
  logic             alu_en_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             capture_s;

  assign in_ready_o = ~valid_q | out_ready_i;
  assign capture_s  = in_valid_i & in_ready_o & ~flush_i;

  // ID/EX register: flush beats capture, capture beats drain, otherwise hold
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q  <= 1'b0;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      store_q  <= {XLEN{1'b0}};
      funct_q  <= 4'b0000;
      alu_en_q <= 1'b0;
      rd_q     <= 5'd0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (capture_s) begin
      valid_q  <= 1'b1;
      a_q      <= a_d;
      b_q      <= b_d;
      store_q  <= store_d;
      funct_q  <= funct_d;
      alu_en_q <= alu_en_d;
      rd_q     <= rd_d;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Saturating stall counter: counts cycles held by downstream back-pressure
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else if (valid_q && !out_ready_i && !flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1'b1);
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign out_valid_o      = valid_q;
  assign out_a_o          = a_q;
  assign out_b_o          = b_q;
  assign out_store_data_o = store_q;
  assign out_funct_o      = funct_q;
  assign out_alu_en_o     = alu_en_q;
  assign out_rd_o         = rd_q;
  assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [3:0]  fn;
    logic        en;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_alu_en;
  logic [31:0] out_a, out_b, out_st;
  logic [3:0]  out_funct;
  logic [4:0]  out_rd;
  logic [15:0] stall_cnt;

  logic        in_ready64, out_valid64, out_alu_en64;
  logic [63:0] out_a64, out_b64, out_st64;
  logic [3:0]  out_funct64;
  logic [4:0]  out_rd64;
  logic [15:0] stall_cnt64;

  logic        in_ready_c2, out_valid_c2, out_alu_en_c2;
  logic [31:0] out_a_c2, out_b_c2, out_st_c2;
  logic [3:0]  out_funct_c2;
  logic [4:0]  out_rd_c2;
  logic [1:0]  stall_cnt_c2;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .NFWD(2), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .fwd_valid_i(fwd_valid), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_a_o(out_a), .out_b_o(out_b), .out_store_data_o(out_st),
    .out_funct_o(out_funct), .out_alu_en_o(out_alu_en), .out_rd_o(out_rd),
    .stall_cnt_o(stall_cnt)
  );

  alu_operand_stage #(.XLEN(64), .NFWD(2), .CNT_W(16)) dut64 (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .instr_i(instr), .pc_i({32'b0, pc}), .rs1_data_i({32'b0, rs1_data}),
    .rs2_data_i({32'b0, rs2_data}), .fwd_valid_i(fwd_valid), .fwd_rd_i(fwd_rd),
    .fwd_data_i({32'b0, fwd_data[63:32], 32'b0, fwd_data[31:0]}),
    .flush_i(flush), .out_valid_o(out_valid64), .out_ready_i(out_ready),
    .out_a_o(out_a64), .out_b_o(out_b64), .out_store_data_o(out_st64),
    .out_funct_o(out_funct64), .out_alu_en_o(out_alu_en64), .out_rd_o(out_rd64),
    .stall_cnt_o(stall_cnt64)
  );

  alu_operand_stage #(.XLEN(32), .NFWD(2), .CNT_W(2)) dut_c2 (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready_c2),
    .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .fwd_valid_i(fwd_valid), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
    .flush_i(flush), .out_valid_o(out_valid_c2), .out_ready_i(out_ready),
    .out_a_o(out_a_c2), .out_b_o(out_b_c2), .out_store_data_o(out_st_c2),
    .out_funct_o(out_funct_c2), .out_alu_en_o(out_alu_en_c2), .out_rd_o(out_rd_c2),
    .stall_cnt_o(stall_cnt_c2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                              input logic [3:0] fn, input logic en, input logic [4:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.st = st; e.fn = fn; e.en = en; e.rd = rd;
    return e;
  endfunction

  // Offer one instruction. Push its expected result once the handshake is seen.
  // The forwarding inputs are set by the caller beforehand and cleared here.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc_v, input logic [31:0] r1,
                      input logic [31:0] r2, input logic push, input exp_t e);
    int n;
    in_valid = 1'b1; instr = ins; pc = pc_v; rs1_data = r1; rs2_data = r2;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
    end else if (push) begin
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fwd_valid = 2'b00;
  endtask

  // Scoreboard monitor: every completed output handshake pops one expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_a", {32'b0, out_a}, {32'b0, mon_e.a});
        check("sb_b", {32'b0, out_b}, {32'b0, mon_e.b});
        check("sb_store", {32'b0, out_st}, {32'b0, mon_e.st});
        check("sb_funct_en_rd", {54'b0, out_funct, out_alu_en, out_rd},
              {54'b0, mon_e.fn, mon_e.en, mon_e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = 32'd0; pc = 32'd0; rs1_data = 32'd0;
    rs2_data = 32'd0; fwd_valid = 2'b00; fwd_rd = 10'd0; fwd_data = 64'd0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'b0, out_valid}, 64'd0);
    check("rst_data", {out_a, out_b}, 64'd0);
    check("rst_misc", {out_st, 16'b0, out_funct, out_alu_en, out_rd, 6'b0}, 64'd0);
    check("rst_cnt", {48'b0, stall_cnt}, 64'd0);
    reset = 1'b0;
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Streaming directed vectors (downstream always ready)
    send(32'hFFD08293, 32'h0, 32'd10, 32'd0, 1'b1, mk(32'd10, 32'hFFFFFFFD, 32'd0, 4'h0, 1'b1, 5'd5));  // ADDI x5,x1,-3
    send(32'h4071D113, 32'h0, 32'h80, 32'd0, 1'b1, mk(32'h80, 32'd7, 32'd0, 4'hD, 1'b1, 5'd2));         // SRAI x2,x3,7
    send(32'h40838333, 32'h0, 32'd100, 32'd30, 1'b1, mk(32'd100, 32'd30, 32'd0, 4'h8, 1'b1, 5'd6));     // SUB x6,x7,x8
    send(32'h008384B3, 32'h0, 32'd5, 32'd6, 1'b1, mk(32'd5, 32'd6, 32'd0, 4'h0, 1'b1, 5'd9));           // ADD x9,x7,x8
    send(32'h01F11093, 32'h0, 32'd3, 32'd0, 1'b1, mk(32'd3, 32'd31, 32'd0, 4'h1, 1'b1, 5'd1));          // SLLI x1,x2,31
    send(32'h40017093, 32'h0, 32'd3, 32'd0, 1'b1, mk(32'd3, 32'h400, 32'd0, 4'h7, 1'b1, 5'd1));         // ANDI x1,x2,0x400
    send(32'hFFC7A703, 32'h0, 32'h400, 32'd0, 1'b1, mk(32'h400, 32'hFFFFFFFC, 32'd0, 4'h0, 1'b1, 5'd14)); // LW x14,-4(x15)
    fwd_valid = 2'b11; fwd_rd = {5'd4, 5'd4}; fwd_data = {32'hBB, 32'hAA};
    send(32'h00020513, 32'h0, 32'h11, 32'd0, 1'b1, mk(32'hAA, 32'd0, 32'd0, 4'h0, 1'b1, 5'd10));        // ADDI x10,x4,0: fwd0 wins
    fwd_valid = 2'b10; fwd_rd = {5'd4, 5'd4}; fwd_data = {32'hBB, 32'hAA};
    send(32'h00020513, 32'h0, 32'h11, 32'd0, 1'b1, mk(32'hBB, 32'd0, 32'd0, 4'h0, 1'b1, 5'd10));        // only fwd1 valid
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hCC};
    send(32'h00500593, 32'h0, 32'h77, 32'd0, 1'b1, mk(32'd0, 32'd5, 32'd0, 4'h0, 1'b1, 5'd11));         // ADDI x11,x0,5
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd12}; fwd_data = {32'h0, 32'h99};
    send(32'h00C6A423, 32'h0, 32'h1000, 32'h55, 1'b1, mk(32'h1000, 32'd8, 32'h99, 4'h0, 1'b1, 5'd0));   // SW x12,8(x13)
    send(32'h12345097, 32'h1000, 32'd0, 32'd0, 1'b1, mk(32'h1000, 32'h12345000, 32'd0, 4'h0, 1'b1, 5'd1)); // AUIPC
    send(32'h008000EF, 32'h2000, 32'd0, 32'd0, 1'b1, mk(32'h2000, 32'd4, 32'd0, 4'h0, 1'b1, 5'd1));     // JAL x1
    send(32'h800011B7, 32'h0, 32'd0, 32'd0, 1'b1, mk(32'd0, 32'h80001000, 32'd0, 4'h0, 1'b1, 5'd3));    // LUI x3
    check("rv64_lui_b", out_b64, 64'hFFFFFFFF80001000);
    send(32'h00000FFF, 32'h0, 32'h5, 32'h6, 1'b1, mk(32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 5'd0));           // unknown opcode
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: six stalled cycles
    out_ready = 1'b0;
    send(32'hFFD08293, 32'h0, 32'd10, 32'd0, 1'b1, mk(32'd10, 32'hFFFFFFFD, 32'd0, 4'h0, 1'b1, 5'd5));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", {63'b0, in_ready}, 64'd0);
      check("stall_hold_a", {32'b0, out_a}, 64'd10);
    end
    check("stall_cnt5", {48'b0, stall_cnt}, 64'd5);
    @(posedge clk);
    #1;
    check("stall_cnt6", {48'b0, stall_cnt}, 64'd6);
    check("cnt2_saturate", {62'b0, stall_cnt_c2}, 64'd3);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain_valid", {63'b0, out_valid}, 64'd0);

    // Flush during a stall: the item is dropped and counting stops
    out_ready = 1'b0;
    send(32'h008384B3, 32'h0, 32'd1, 32'd2, 1'b0, mk(32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 5'd0));
    repeat (3) @(posedge clk);
    #1;
    check("flush_pre_cnt", {48'b0, stall_cnt}, 64'd9);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_valid", {63'b0, out_valid}, 64'd0);
    check("flush_cnt", {48'b0, stall_cnt}, 64'd9);
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("flush_cnt_hold", {48'b0, stall_cnt}, 64'd9);

    // Reset in the middle of a stall
    send(32'h12345097, 32'h1000, 32'd0, 32'd0, 1'b0, mk(32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 5'd0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_cnt", {48'b0, stall_cnt}, 64'd0);
    check("mid_rst_data", {out_a, out_b}, 64'd0);
    check("mid_rst_misc", {out_st, 16'b0, out_funct, out_alu_en, out_rd, 6'b0}, 64'd0);
    check("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("mid_rst_cnt2", {62'b0, stall_cnt_c2}, 64'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered successor to the combinational ALU operand selector.
- Decodes a raw RV32I/RV64I instruction and picks ALU operands A/B.
- Resolves register hazards through parametrised forwarding ports.
- Presents the result in an ID/EX pipeline register with a valid/ready handshake, flush and a stall-cycle counter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
NFWD, 2, number of forwarding sources; index 0 is the youngest (highest priority)
CNT_W, 16, width of saturating stall counter

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
IN_VALID  in  1  upstream has an instruction
IN_READY  out  1  stage can accept this cycle
INSTR  in  32  raw instruction word
PC  in  XLEN  instruction address
RS1_DATA  in  XLEN  regfile read of rs1
RS2_DATA  in  XLEN  regfile read of rs2
FWD_VALID  in  NFWD  forwarding source i valid
FWD_RD  in  5*NFWD  destination register of source i (slice i = [5i+4:5i])
FWD_DATA  in  XLEN*NFWD  result of source i
FLUSH  in  1  squash stage contents
OUT_VALID  out  1  registered operands valid
OUT_READY  in  1  downstream accepts
OUT_A  out  XLEN  operand A
OUT_B  out  XLEN  operand B
OUT_STORE_DATA  out  XLEN  forwarded rs2 for stores, else 0
OUT_FUNCT  out  4  {alt bit, funct3} ALU function
OUT_ALU_EN  out  1  instruction uses ALU
OUT_RD  out  5  destination register
STALL_CNT  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: all outputs, including STALL_CNT, are 0.
- IN_READY is combinational: ~OUT_VALID | OUT_READY.
- Capture happens when IN_VALID & IN_READY & ~FLUSH.
  - All output registers load at the next edge; latency is 1 cycle.
  - OUT_VALID goes to 1.
- If OUT_READY & ~capture, OUT_VALID goes to 0 and the data registers hold.
- If OUT_VALID & ~OUT_READY, all registers hold (stall).
- FLUSH has priority over capture and stall: OUT_VALID goes to 0 next cycle; the data registers are don't-care.
- Forwarding is evaluated at capture only.
  - For each of rs1 and rs2, take the lowest index i with FWD_VALID[i] & FWD_RD_i == rs & rs != 0. Otherwise use RS*_DATA.
  - x0 always reads 0, regardless of RS*_DATA or forwarding.
- Immediates are sign-extended to XLEN:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - U = {instr[31:12], 12'b0}
  - shamt = instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64), zero-extended.
- Decode by opcode (A / B / OUT_FUNCT / ALU_EN):
  - 0010011 OP-IMM: rs1 / I, or shamt when funct3 is 001 or 101 / {funct3==101 ? instr[30] : 0, funct3} / 1
  - 0110011 OP: rs1 / rs2 / {instr[30], funct3} / 1
  - 0000011 LOAD: rs1 / I / 0000 / 1
  - 0100011 STORE: rs1 / S / 0000 / 1; OUT_STORE_DATA = forwarded rs2
  - 0110111 LUI: 0 / U / 0000 / 1
  - 0010111 AUIPC: PC / U / 0000 / 1
  - 1101111 JAL and 1100111 JALR: PC / 4 / 0000 / 1 (link address)
  - any other opcode: 0 / 0 / 0000 / 0
- OUT_RD = instr[11:7] for opcodes that write a register; 0 for STORE and unknown opcodes.
- STALL_CNT increments each cycle OUT_VALID & ~OUT_READY & ~FLUSH and saturates at all-ones. It clears only on RESET.
- RESET mid-stall: next cycle OUT_VALID=0 and STALL_CNT=0; IN_READY=1 from that cycle on.

Test Plan:
- ADDI x5,x1,-3 with RS1_DATA=10, no forwarding: OUT_A=10, OUT_B=0xFFFFFFFD, OUT_FUNCT=0000, OUT_RD=5, valid 1 cycle after capture.
- SRAI x2,x3,7 (instr[30]=1): OUT_B=7, OUT_FUNCT=1101. SUB: OUT_FUNCT=1000. ADD: OUT_FUNCT=0000.
- Forwarding on rs1=4 with FWD0={1,4,0xAA} and FWD1={1,4,0xBB}: OUT_A=0xAA. rs1=0 with FWD0={1,0,0xCC}: OUT_A=0.
- AUIPC with PC=0x1000 and imm=0x12345: OUT_A=0x1000, OUT_B=0x12345000. JAL: OUT_B=4. For XLEN=64 LUI with imm bit31=1: upper 32 bits of OUT_B are 1s.
- Hold OUT_READY=0 for 5 cycles with OUT_VALID=1: IN_READY=0, outputs stable, STALL_CNT=5. FLUSH in cycle 3: OUT_VALID=0 next cycle and counting stops at 3.
- CNT_W=2, stall 6 cycles: STALL_CNT saturates at 3. Pulse RESET: all outputs 0 next cycle.
